weight_mem_sched: RTL and testbench

//  Owns the single-port perceptron weight RAM (latch memory) and sequences every access to it.

---
 rtl/weight_mem_sched_pkg.sv | 17 +
 rtl/weight_mem_sched_if.sv | 34 +++
 rtl/weight_mem_sched_sat_step.sv | 11 +
 rtl/weight_mem_sched.sv | 102 ++++++++++
 tb/tb_weight_mem_sched.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_mem_sched_pkg.sv
// weight_mem_sched_pkg: shared constants, state encoding and address helper for the weight scheduler
package weight_mem_sched_pkg;
  localparam int H         = 15;
  localparam int WW        = 8;
  localparam int STORAGE_B = 128;
  localparam int AW        = $clog2(STORAGE_B);
  localparam int NW        = H + 1;
  localparam int LOG_NW    = $clog2(NW);
  localparam int PIDX_W    = $clog2(STORAGE_B / NW);
  localparam int CNT_W     = AW;
  localparam logic [WW-1:0] WMAX = 8'h7F;
  localparam logic [WW-1:0] WMIN = 8'h80;
  typedef enum logic [2:0] {IDLE, CLEAR, PRED, TRAIN_RD, TRAIN_WR} state_t;
  function automatic logic [AW-1:0] base_addr(input logic [PIDX_W-1:0] idx);
    return {idx, {LOG_NW{1'b0}}};
  endfunction
endpackage

// File: rtl/weight_mem_sched_if.sv
// weight_mem_sched_if: request/grant, weight stream, training and RAM bus of the weight scheduler
interface weight_mem_sched_if;
  import weight_mem_sched_pkg::*;
  logic              clear_req;
  logic              pred_req;
  logic [PIDX_W-1:0] pred_idx;
  logic              pred_gnt;
  logic              rd_valid;
  logic [WW-1:0]     rd_data;
  logic [LOG_NW-1:0] rd_idx;
  logic              rd_last;
  logic              train_req;
  logic [PIDX_W-1:0] train_idx;
  logic [H-1:0]      train_hist;
  logic              train_taken;
  logic              train_gnt;
  logic              train_done;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en;
  logic [WW-1:0]     mem_wdata;
  logic [WW-1:0]     mem_rdata;
  logic              busy;
  logic              init_done;
  modport slave (
    input  clear_req, pred_req, pred_idx, train_req, train_idx, train_hist, train_taken, mem_rdata,
    output pred_gnt, rd_valid, rd_data, rd_idx, rd_last, train_gnt, train_done,
           mem_addr, mem_wr_en, mem_wdata, busy, init_done
  );
  modport master (
    output clear_req, pred_req, pred_idx, train_req, train_idx, train_hist, train_taken, mem_rdata,
    input  pred_gnt, rd_valid, rd_data, rd_idx, rd_last, train_gnt, train_done,
           mem_addr, mem_wr_en, mem_wdata, busy, init_done
  );
endinterface

// File: rtl/weight_mem_sched_sat_step.sv
// weight_mem_sched_sat_step: one perceptron training step on a signed weight, saturating at +127/-128
module weight_mem_sched_sat_step
  import weight_mem_sched_pkg::*;
(
  input  logic [WW-1:0] i_w,
  input  logic          i_agree,
  output logic [WW-1:0] o_w
);
  assign o_w = i_agree ? (i_w == WMAX ? i_w : i_w + WW'(1))
                       : (i_w == WMIN ? i_w : i_w - WW'(1));
endmodule

// File: rtl/weight_mem_sched.sv
// weight_mem_sched: sequences every access to the single-port weight RAM
// (post-reset clear, weight streaming, saturating read-modify-write training)
module weight_mem_sched
  import weight_mem_sched_pkg::*;
(
  input logic clk,
  input logic rst_n,
  weight_mem_sched_if.slave sched
);
  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [PIDX_W-1:0]   r_idx;
  logic [H-1:0]        r_hist;
  logic                r_taken;
  logic                r_pred_gnt, r_train_gnt, r_rd_valid, r_rd_last;
  logic                r_train_done, r_busy, r_init_done;
  logic [WW-1:0]       r_rd_data;
  logic [LOG_NW-1:0]   r_rd_idx;
  logic [LOG_NW-1:0]   w_k;
  logic [H:0]          w_x;
  logic                w_arb;
  logic [WW-1:0]       w_sat;

  assign w_k = r_cnt[LOG_NW-1:0];
  assign w_x = {r_hist, 1'b1};
  // grants are issued at the edge entering an IDLE cycle so the grant pulse marks that cycle
  assign w_arb = (w_next == IDLE) && !sched.clear_req;

  weight_mem_sched_sat_step u_sat (
    .i_w     (sched.mem_rdata),
    .i_agree (w_x[w_k] == r_taken),
    .o_w     (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = !r_init_done ? CLEAR : r_train_gnt ? TRAIN_RD : r_pred_gnt ? PRED :
                         sched.clear_req ? CLEAR : IDLE;
      CLEAR:    w_next = r_cnt == CNT_W'(STORAGE_B - 1) ? IDLE : CLEAR;
      PRED:     w_next = r_cnt == CNT_W'(NW) ? IDLE : PRED;
      TRAIN_RD: w_next = TRAIN_WR;
      TRAIN_WR: w_next = r_cnt == CNT_W'(H) ? IDLE : TRAIN_RD;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    sched.mem_wr_en = r_state == CLEAR || r_state == TRAIN_WR;
    sched.mem_addr  = r_state == CLEAR ? r_cnt : base_addr(r_idx) | AW'(w_k);
    sched.mem_wdata = r_state == TRAIN_WR ? w_sat : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_hist       <= '0;
      r_taken      <= 1'b0;
      r_pred_gnt   <= 1'b0;
      r_train_gnt  <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_idx     <= '0;
      r_rd_last    <= 1'b0;
      r_train_done <= 1'b0;
      r_busy       <= 1'b0;
      r_init_done  <= 1'b0;
    end else begin
      r_train_gnt  <= w_arb && sched.train_req;
      r_pred_gnt   <= w_arb && !sched.train_req && sched.pred_req;
      if (r_train_gnt) begin
        r_idx   <= sched.train_idx;
        r_hist  <= sched.train_hist;
        r_taken <= sched.train_taken;
      end else if (r_pred_gnt) r_idx <= sched.pred_idx;
      r_cnt        <= r_state == IDLE ? '0 : r_cnt + CNT_W'(r_state != TRAIN_RD);
      r_rd_valid   <= r_state == PRED && r_cnt != '0;
      if (r_state == PRED && r_cnt != '0) begin
        r_rd_data <= sched.mem_rdata;
        r_rd_idx  <= w_k - LOG_NW'(1);
      end
      r_rd_last    <= r_state == PRED && r_cnt == CNT_W'(NW);
      r_train_done <= r_state == TRAIN_WR && r_cnt == CNT_W'(H);
      r_busy       <= w_next != IDLE;
      r_init_done  <= r_init_done || (r_state == CLEAR && w_next == IDLE);
    end

  assign sched.pred_gnt   = r_pred_gnt;
  assign sched.train_gnt  = r_train_gnt;
  assign sched.rd_valid   = r_rd_valid;
  assign sched.rd_data    = r_rd_data;
  assign sched.rd_idx     = r_rd_idx;
  assign sched.rd_last    = r_rd_last;
  assign sched.train_done = r_train_done;
  assign sched.busy       = r_busy;
  assign sched.init_done  = r_init_done;
endmodule

// File: tb/tb_weight_mem_sched.sv
// tb_weight_mem_sched: randomized checks of clear, streaming, training and reset abort
// against an array-based model of the weight RAM
module tb_weight_mem_sched;
  import weight_mem_sched_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  weight_mem_sched_if bus();
  weight_mem_sched dut (.clk(clk), .rst_n(rst_n), .sched(bus));

  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  logic       pl_en = 1'b0;
  logic [6:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_cmp = 0, n_fail = 0;
  int g_addr [16];
  logic [7:0] g_data [$];
  int g_ridx [$];
  bit g_last [$];

  function automatic logic [7:0] sat_ref(logic [7:0] w, bit agree);
    int v;
    v = int'($signed(w)) + (agree ? 1 : -1);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic ref_train(int idx, logic [14:0] hist, bit taken);
    for (int k = 0; k < 16; k++) begin
      bit x;
      x = (k == 0) ? 1'b1 : hist[k-1];
      ref_mem[idx*16+k] = sat_ref(ref_mem[idx*16+k], x == taken);
    end
  endtask

  task automatic preload(int a, logic [7:0] d);
    pl_en = 1'b1; pl_addr = 7'(a); pl_data = d; ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = !bus.busy && !bus.pred_gnt && !bus.train_gnt;
    end
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL %s: still busy after %0d cycles, required idle", name, budget); end
  endtask

  task automatic run_pred(int idx, output bit ok);
    bus.pred_idx = 3'(idx); bus.pred_req = 1'b1; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = bus.pred_gnt; end
    bus.pred_req = 1'b0;
    g_data.delete(); g_ridx.delete(); g_last.delete();
    if (!ok) return;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      if (j == 1) bus.pred_idx = 3'($urandom);
      if (j <= 16) g_addr[j-1] = int'(bus.mem_addr);
      if (bus.rd_valid) begin g_data.push_back(bus.rd_data); g_ridx.push_back(int'(bus.rd_idx)); g_last.push_back(bus.rd_last); end
    end
  endtask

  task automatic run_train(int idx, logic [14:0] hist, bit taken, output bit ok,
                           output int first_addr, output int done_off, output int nwr, output bit order_ok);
    bus.train_idx = 3'(idx); bus.train_hist = hist; bus.train_taken = taken; bus.train_req = 1'b1; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = bus.train_gnt; end
    bus.train_req = 1'b0; first_addr = -1; done_off = -1; nwr = 0; order_ok = 1;
    if (!ok) return;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (j == 1) begin
        first_addr = bus.mem_wr_en ? -2 : int'(bus.mem_addr);
        bus.train_hist = 15'($urandom); bus.train_taken = 1'($urandom); bus.train_idx = 3'($urandom);
      end
      if (bus.mem_wr_en) begin
        if (bus.mem_addr !== 7'(idx*16+nwr)) order_ok = 0;
        nwr++;
      end
      if (bus.train_done && done_off < 0) done_off = j;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.init_done, bus.pred_gnt, bus.train_gnt, bus.rd_valid, bus.train_done, bus.mem_wr_en} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0", {bus.busy, bus.init_done, bus.pred_gnt, bus.train_gnt, bus.rd_valid, bus.train_done, bus.mem_wr_en});
    end
    n_cmp++;
    if (bus.mem_addr !== 7'd0) begin n_fail++; $display("FAIL reset_addr: got %0h required 0", bus.mem_addr); end
  endtask

  task automatic test_clear;
    int nwr = 0;
    bit bad = 0, early = 0, seen = 0;
    for (int a = 0; a < 128; a++) ref_mem[a] = 8'h00;
    bus.pred_idx = 3'd5; bus.pred_req = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        if (bus.mem_addr !== 7'(nwr) || bus.mem_wdata !== 8'h00) bad = 1;
        nwr++;
      end
      if (bus.pred_gnt && !bus.init_done) early = 1;
      seen = bus.init_done;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL clear_init_done: got 0 required 1"); end
    n_cmp++; if (nwr != 128) begin n_fail++; $display("FAIL clear_writes: got %0d required 128", nwr); end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL clear_order: got out-of-order or nonzero write, required addr 0..127 data 0"); end
    n_cmp++; if (early) begin n_fail++; $display("FAIL clear_early_gnt: got pred_gnt before init_done, required none"); end
    n_cmp++; if (bus.pred_gnt !== 1'b1) begin n_fail++; $display("FAIL clear_gnt_after: got %b required 1", bus.pred_gnt); end
    bus.pred_req = 1'b0;
    wait_idle("clear_pred_drain", 40);
  endtask

  task automatic test_pred_stream;
    for (int r = 0; r < 4; r++) begin
      bit ok;
      int idx;
      idx = (r == 0) ? 3 : int'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) preload(idx*16+k, (r == 0) ? 8'(k) : 8'($urandom));
      run_pred(idx, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL pred_gnt[%0d]: got no grant required grant", r); continue; end
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (g_addr[k] != idx*16+k) begin n_fail++; $display("FAIL pred_addr[%0d.%0d]: got %0d required %0d", r, k, g_addr[k], idx*16+k); end
      end
      n_cmp++;
      if (g_data.size() != 16) begin n_fail++; $display("FAIL pred_beats[%0d]: got %0d required 16", r, g_data.size()); continue; end
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (g_data[k] !== ref_mem[idx*16+k] || g_ridx[k] != k || g_last[k] != (k == 15)) begin
          n_fail++; $display("FAIL pred_beat[%0d.%0d]: got data %0h idx %0d last %0b required %0h %0d %0b",
                             r, k, g_data[k], g_ridx[k], g_last[k], ref_mem[idx*16+k], k, k == 15);
        end
      end
    end
  endtask

  task automatic test_train;
    logic [7:0] edges [4] = '{8'h7F, 8'h80, 8'h7E, 8'h81};
    for (int r = 0; r < 5; r++) begin
      bit ok, order_ok, taken;
      int idx, fa, done_off, nwr;
      logic [14:0] hist;
      idx   = (r == 0) ? 1 : int'($urandom_range(0, 7));
      hist  = (r == 0) ? 15'h5555 : 15'($urandom);
      taken = (r == 0) ? 1'b1 : 1'($urandom);
      for (int k = 0; k < 16; k++)
        preload(idx*16+k, (r == 0) ? 8'h00 : ($urandom_range(0, 1) != 0) ? edges[$urandom_range(0, 3)] : 8'($urandom));
      run_train(idx, hist, taken, ok, fa, done_off, nwr, order_ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL train_gnt[%0d]: got no grant required grant", r); continue; end
      n_cmp++; if (fa != idx*16) begin n_fail++; $display("FAIL train_first_rd[%0d]: got %0d required %0d", r, fa, idx*16); end
      n_cmp++; if (done_off - 1 != 32) begin n_fail++; $display("FAIL train_done_lat[%0d]: got %0d required 32", r, done_off - 1); end
      n_cmp++; if (nwr != 16 || !order_ok) begin n_fail++; $display("FAIL train_writes[%0d]: got %0d ordered %0b required 16 ordered 1", r, nwr, order_ok); end
      ref_train(idx, hist, taken);
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (mem[idx*16+k] !== ref_mem[idx*16+k]) begin n_fail++; $display("FAIL train_w[%0d.%0d]: got %0h required %0h", r, k, mem[idx*16+k], ref_mem[idx*16+k]); end
      end
      if (r == 0) begin
        n_cmp++;
        if (mem[16] !== 8'h01 || mem[17] !== 8'h01 || mem[18] !== 8'hFF) begin
          n_fail++; $display("FAIL train_5555: got %0h %0h %0h required 01 01 ff", mem[16], mem[17], mem[18]);
        end
      end
    end
  endtask

  task automatic test_saturation;
    for (int r = 0; r < 2; r++) begin
      bit ok, order_ok;
      int idx, fa, done_off, nwr;
      logic [7:0] v;
      v = (r == 0) ? 8'h7F : 8'h80;
      idx = int'($urandom_range(0, 7));
      for (int k = 0; k < 16; k++) preload(idx*16+k, v);
      run_train(idx, 15'h7FFF, r == 0, ok, fa, done_off, nwr, order_ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL sat_gnt[%0d]: got no grant required grant", r); continue; end
      ref_train(idx, 15'h7FFF, r == 0);
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (mem[idx*16+k] !== v) begin n_fail++; $display("FAIL sat_w[%0d.%0d]: got %0h required %0h", r, k, mem[idx*16+k], v); end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit got = 0, done = 0;
    int idx;
    logic [14:0] hist;
    bit taken;
    idx = int'($urandom_range(0, 7)); hist = 15'($urandom); taken = 1'($urandom);
    bus.train_idx = 3'(idx); bus.train_hist = hist; bus.train_taken = taken;
    bus.pred_idx = 3'($urandom); bus.train_req = 1'b1; bus.pred_req = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = bus.train_gnt || bus.pred_gnt; end
    n_cmp++;
    if (!(bus.train_gnt === 1'b1 && bus.pred_gnt === 1'b0)) begin
      n_fail++; $display("FAIL b2b_first: got train_gnt %b pred_gnt %b required 1 0", bus.train_gnt, bus.pred_gnt);
    end
    bus.train_req = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin @(negedge clk); done = bus.train_done; end
    n_cmp++;
    if (!done || bus.pred_gnt !== 1'b1) begin
      n_fail++; $display("FAIL b2b_pred_gnt: got done %b pred_gnt %b required 1 1", done, bus.pred_gnt);
    end
    bus.pred_req = 1'b0;
    wait_idle("b2b_drain", 40);
    ref_train(idx, hist, taken);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (mem[idx*16+k] !== ref_mem[idx*16+k]) begin n_fail++; $display("FAIL b2b_w[%0d]: got %0h required %0h", k, mem[idx*16+k], ref_mem[idx*16+k]); end
    end
  endtask

  task automatic test_clear_req;
    preload(100, 8'h5A);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    wait_idle("clear_req_run", 300);
    for (int a = 0; a < 128; a++) ref_mem[a] = 8'h00;
    n_cmp++; if (mem[100] !== 8'h00) begin n_fail++; $display("FAIL clear_req_byte: got %0h required 0", mem[100]); end
    n_cmp++; if (bus.init_done !== 1'b1) begin n_fail++; $display("FAIL clear_req_init: got %b required 1", bus.init_done); end
  endtask

  task automatic test_reset_mid_train;
    bit ok = 0, hit = 0, seen = 0;
    int idx, bad = 0, first_bad = -1;
    idx = int'($urandom_range(0, 7));
    for (int k = 0; k < 16; k++) preload(idx*16+k, 8'($urandom));
    bus.train_idx = 3'(idx); bus.train_hist = 15'($urandom); bus.train_taken = 1'($urandom); bus.train_req = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = bus.train_gnt; end
    bus.train_req = 1'b0;
    for (int i = 0; i < 40 && ok && !hit; i++) begin
      @(negedge clk);
      hit = bus.mem_wr_en && bus.mem_addr == 7'(idx*16+7);
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach_k7: got no write of k=7 required one"); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.init_done, bus.mem_wr_en, bus.train_done, bus.train_gnt, bus.rd_valid} !== 6'b0 || bus.mem_addr !== 7'd0) begin
      n_fail++; $display("FAIL abort_outputs: got %b addr %0h required 0", {bus.busy, bus.init_done, bus.mem_wr_en, bus.train_done, bus.train_gnt, bus.rd_valid}, bus.mem_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin @(negedge clk); seen = bus.init_done; end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL abort_reclear: got init_done 0 required 1"); end
    for (int a = 0; a < 128; a++) begin
      ref_mem[a] = 8'h00;
      if (mem[a] !== ref_mem[a]) begin bad++; if (first_bad < 0) first_bad = a; end
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL abort_mem_zero: got %0d nonzero bytes (first %0d) required 0", bad, first_bad); end
  endtask

  initial begin
    bus.clear_req = 1'b0; bus.pred_req = 1'b0; bus.pred_idx = '0;
    bus.train_req = 1'b0; bus.train_idx = '0; bus.train_hist = '0; bus.train_taken = 1'b0;
    test_reset();
    test_clear();
    test_pred_stream();
    test_train();
    test_saturation();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_train();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
